// File: rtl/gb_ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_ppu_pkg
// Description : Shared constants and types for the PPU sprite (OAM) scan:
//               OAM base address and sizes, the per-sprite queue entry layout
//               and the scan state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_ppu_pkg;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_ENTRIES = 40;
  localparam int          MAX_SPRITES = 10;
  localparam int          OAM_BYTES   = OAM_ENTRIES * 4;

  // Field order gives {y, x, tile, attr, idx} from MSB to LSB (40 bits).
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] idx;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_match.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_match
// Description : Combinational test of whether a sprite with top coordinate y
//               covers the current line. The line is offset by 16 to match
//               OAM's Y convention; all arithmetic is 9-bit so nothing wraps.
// Ports       : ly    - current line (latched at scan start)
//               tall  - 1 for 16-pixel sprites, 0 for 8-pixel sprites
//               y     - sprite Y byte from OAM
//               match - sprite covers the line
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_match (
  input  logic [7:0] ly,
  input  logic       tall,
  input  logic [7:0] y,
  output logic       match
);

  logic [8:0] w_line;
  logic [8:0] w_top;
  logic [8:0] w_bottom;

  assign w_line   = {1'b0, ly} + 9'd16;
  assign w_top    = {1'b0, y};
  assign w_bottom = w_top + (tall ? 9'd16 : 9'd8);
  assign match    = (w_line >= w_top) && (w_line < w_bottom);

endmodule
`default_nettype wire

// File: rtl/oam_scan_fsm.sv
`default_nettype none
// ============================================================================
// Module      : oam_scan_fsm
// Description : Scans all 40 OAM entries (160 bytes, one per cycle) for the
//               line latched at start and collects up to 10 sprites that
//               cover it. done_out pulses 162 cycles after start.
//               Build option OAM_SCAN_SORT_X_EN: accepted sprites are
//               inserted in ascending X order (stable for equal X) instead
//               of OAM order; timing is identical.
// Ports       : clk, rst (async, active-low)
//               start, LY, LCDC     - scan request; LY/LCDC[2] sampled on start
//               oam_a, oam_dout     - OAM read port (1-cycle read latency)
//               oam_din, oam_wr     - unused write port, tied to 0
//               sprite_queue/count  - selected sprites, slot 0 first
//               busy, done_out      - scan in progress / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module oam_scan_fsm
  import gb_ppu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       LY,
  input  logic [7:0]       LCDC,
  output logic [15:0]      oam_a,
  input  logic [7:0]       oam_dout,
  output logic [7:0]       oam_din,
  output logic             oam_wr,
  output logic [9:0][39:0] sprite_queue,
  output logic [3:0]       sprite_count,
  output logic             busy,
  output logic             done_out
);

  scan_state_t r_state;
  scan_state_t w_state_nxt;

  // r_n counts address cycles 0..159; value 160 is the read-latency cycle.
  logic [7:0]    r_n;
  logic [7:0]    r_ly;
  logic          r_tall;
  logic [7:0]    r_y;
  logic [7:0]    r_x;
  logic [7:0]    r_tile;
  logic [3:0]    r_count;
  sprite_entry_t [MAX_SPRITES-1:0] r_queue;
  sprite_entry_t [MAX_SPRITES-1:0] w_queue_ins;

  logic [7:0]    w_cap;
  logic          w_match;
  logic          w_accept;
  logic [3:0]    w_pos;
  sprite_entry_t w_new;
  logic          w_unused_lcdc;

  assign w_unused_lcdc = &{LCDC[7:3], LCDC[1:0], 1'b0};

  assign oam_din      = 8'h00;
  assign oam_wr       = 1'b0;
  assign sprite_queue = r_queue;
  assign sprite_count = r_count;

  // ---------------------------------------------------------------------------
  // State register and next-state / output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done_out    = 1'b0;
    oam_a       = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (r_n != 8'(OAM_BYTES)) oam_a = OAM_BASE + {8'h00, r_n};
        if (start)                       w_state_nxt = S_FETCH;
        else if (r_n == 8'(OAM_BYTES))   w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = start ? S_FETCH : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture path: the byte on oam_dout belongs to address r_n-1.
  // ---------------------------------------------------------------------------
  assign w_cap = r_n - 8'd1;
  assign w_new = {r_y, r_x, r_tile, oam_dout, 2'b00, w_cap[7:2]};

  sprite_line_match u_line_match (
    .ly    (r_ly),
    .tall  (r_tall),
    .y     (r_y),
    .match (w_match)
  );

  // Attribute byte is the last of an entry, so the accept decision is made
  // when it arrives; Y/X/tile are already held in r_y/r_x/r_tile.
  assign w_accept = (r_state == S_FETCH) && (r_n != 8'd0) && (w_cap[1:0] == 2'd3)
                  && w_match && (r_count < 4'(MAX_SPRITES));

  // Insertion slot: either the end of the queue or, when sorting, just past
  // every valid entry whose X is <= the new X (queue is already sorted).
  always_comb begin
    w_pos = r_count;
`ifdef OAM_SCAN_SORT_X_EN
    w_pos = 4'd0;
    for (int i = 0; i < MAX_SPRITES; i++) begin
      if ((4'(i) < r_count) && (r_queue[i].x <= r_x)) w_pos = w_pos + 4'd1;
    end
`endif
  end

  for (genvar i = 0; i < MAX_SPRITES; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign w_queue_ins[i] = (w_pos == 4'd0) ? w_new : r_queue[i];
    end else begin : g_tail
      assign w_queue_ins[i] = (4'(i) < w_pos)  ? r_queue[i]   :
                              (4'(i) == w_pos) ? w_new        :
                                                 r_queue[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n     <= 8'd0;
      r_ly    <= 8'd0;
      r_tall  <= 1'b0;
      r_y     <= 8'd0;
      r_x     <= 8'd0;
      r_tile  <= 8'd0;
      r_count <= 4'd0;
      r_queue <= '0;
    end else if (start) begin
      r_n     <= 8'd0;
      r_ly    <= LY;
      r_tall  <= LCDC[2];
      r_count <= 4'd0;
      r_queue <= '0;
    end else if (r_state == S_FETCH) begin
      if (r_n != 8'(OAM_BYTES)) r_n <= r_n + 8'd1;
      if (r_n != 8'd0) begin
        case (w_cap[1:0])
          2'd0:    r_y    <= oam_dout;
          2'd1:    r_x    <= oam_dout;
          2'd2:    r_tile <= oam_dout;
          default: ;
        endcase
      end
      if (w_accept) begin
        r_queue <= w_queue_ins;
        r_count <= r_count + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_scan_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_scan_fsm
// Description : Scoreboard bench for oam_scan_fsm. Each start pushes the
//               expected sprite list and completion cycle, computed from the
//               OAM contents by a list-based model; a monitor pops and checks
//               on every done_out. Build with OAM_SCAN_SORT_X_EN to match a
//               sorting DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_scan_fsm;

  typedef struct packed {
    logic [31:0]       done_cyc;
    logic [3:0]        cnt;
    logic [9:0][39:0]  q;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       LY;
  logic [7:0]       LCDC;
  logic [15:0]      oam_a;
  logic [7:0]       oam_dout;
  logic [7:0]       oam_din;
  logic             oam_wr;
  logic [9:0][39:0] sprite_queue;
  logic [3:0]       sprite_count;
  logic             busy;
  logic             done_out;

  logic [7:0]  mem [160];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  exp_t        last_exp = '0;

  oam_scan_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .LY           (LY),
    .LCDC         (LCDC),
    .oam_a        (oam_a),
    .oam_dout     (oam_dout),
    .oam_din      (oam_din),
    .oam_wr       (oam_wr),
    .sprite_queue (sprite_queue),
    .sprite_count (sprite_count),
    .busy         (busy),
    .done_out     (done_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // OAM memory with one cycle of read latency.
  always @(posedge clk) begin
    if (oam_a >= 16'hFE00 && oam_a < 16'hFEA0) oam_dout <= mem[int'(oam_a - 16'hFE00)];
    else                                        oam_dout <= 8'hFF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: list the first 10 covering entries in OAM order; when sorting,
  // regroup them by ascending X, keeping list order within one X value.
  function automatic exp_t model(input logic [7:0] ly, input logic tall);
    exp_t        e;
    logic [39:0] hits[$];
    int          line;
    int          h;
    e    = '0;
    line = int'(ly) + 16;
    h    = tall ? 16 : 8;
    for (int i = 0; i < 40; i++) begin
      int y;
      y = int'(mem[4*i]);
      if (line >= y && line < y + h && hits.size() < 10)
        hits.push_back({mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3], 8'(i)});
    end
`ifdef OAM_SCAN_SORT_X_EN
    begin
      logic [39:0] sorted[$];
      for (int xv = 0; xv < 256; xv++)
        foreach (hits[j]) if (int'(hits[j][31:24]) == xv) sorted.push_back(hits[j]);
      hits = sorted;
    end
`endif
    e.cnt = 4'(hits.size());
    foreach (hits[j]) e.q[j] = hits[j];
    return e;
  endfunction

  // Monitor: every done_out must correspond to an outstanding scan.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("count", 64'(sprite_count), 64'(e.cnt));
          for (int s = 0; s < 10; s++)
            chk($sformatf("slot%0d", s), 64'(sprite_queue[s]), 64'(e.q[s]));
          last_exp = e;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 160; i++) mem[i] = 8'h00;
  endtask

  task automatic set_entry(input int n, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] tile, input logic [7:0] attr);
    mem[4*n] = y; mem[4*n+1] = x; mem[4*n+2] = tile; mem[4*n+3] = attr;
  endtask

  // Returns with the bench at the negedge of the first cycle after start.
  task automatic issue_start(input logic [7:0] ly, input logic [7:0] lcdc,
                             output int unsigned k);
    exp_t e;
    @(negedge clk);
    k     = cyc;
    LY    = ly;
    LCDC  = lcdc;
    start = 1'b1;
    e          = model(ly, lcdc[2]);
    e.done_cyc = 32'(k + 162);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    LY    = 8'($urandom);
    LCDC  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic check_hold();
    repeat (20) @(negedge clk);
    chk("hold_count", 64'(sprite_count), 64'(last_exp.cnt));
    for (int s = 0; s < 10; s++)
      chk($sformatf("hold_slot%0d", s), 64'(sprite_queue[s]), 64'(last_exp.q[s]));
  endtask

  task automatic run_scan(input logic [7:0] ly, input logic [7:0] lcdc);
    int unsigned k;
    issue_start(ly, lcdc, k);
    chk("busy_first", 64'(busy), 1);
    chk("oam_a_first", 64'(oam_a), 64'h FE00);
    while (cyc < k + 160) @(negedge clk);
    chk("oam_a_last", 64'(oam_a), 64'h FE9F);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("busy_after", 64'(busy), 0);
    check_hold();
  endtask

  initial begin
    int unsigned k;
    rst   = 1'b0;
    start = 1'b0;
    LY    = 8'h00;
    LCDC  = 8'h00;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(sprite_count), 0);
    chk("rst_queue_or", 64'(|sprite_queue), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done_out), 0);
    chk("rst_oam_a", 64'(oam_a), 0);
    chk("rst_oam_wr", 64'({oam_wr, oam_din}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single 8-pixel sprite at the top of line 0.
    set_entry(0, 8'd16, 8'd8, 8'h12, 8'h80);
    run_scan(8'd0, 8'h00);
    chk("single_slot0", 64'(sprite_queue[0]), 64'h10_0812_8000);
    chk("single_count", 64'(sprite_count), 1);

    // Entry 7 only reaches line 5 with 16-pixel sprites; entry 3 with either.
    clear_mem();
    set_entry(3, 8'd14, 8'd40, 8'h01, 8'h00);
    set_entry(7, 8'd6,  8'd30, 8'h02, 8'h00);
    run_scan(8'd5, 8'h04);
    chk("tall_count", 64'(sprite_count), 2);
    chk("tall_idx0", 64'(sprite_queue[0][7:0]), 3);
    chk("tall_idx1", 64'(sprite_queue[1][7:0]), 7);
    run_scan(8'd5, 8'h00);
    chk("short_count", 64'(sprite_count), 1);
    chk("short_idx0", 64'(sprite_queue[0][7:0]), 3);

    // All 40 entries cover the line: capped at 10, idx 0-9.
    for (int i = 0; i < 40; i++) set_entry(i, 8'd16, 8'(200 - i), 8'(i), 8'h00);
    run_scan(8'd0, 8'h00);
    chk("full_count", 64'(sprite_count), 10);
`ifndef OAM_SCAN_SORT_X_EN
    chk("full_idx9", 64'(sprite_queue[9][7:0]), 9);
`endif

    // X ordering; X = 0 and X >= 168 are not filtered.
    clear_mem();
    set_entry(0, 8'd16, 8'd50, 8'h00, 8'h00);
    set_entry(1, 8'd16, 8'd20, 8'h00, 8'h00);
    set_entry(2, 8'd16, 8'd50, 8'h00, 8'h00);
    set_entry(3, 8'd16, 8'd10, 8'h00, 8'h00);
    set_entry(4, 8'd16, 8'd0,  8'h00, 8'h00);
    set_entry(5, 8'd16, 8'd200, 8'h00, 8'h00);
    run_scan(8'd0, 8'h00);
    chk("x_count", 64'(sprite_count), 6);
`ifdef OAM_SCAN_SORT_X_EN
    chk("sort_order", 64'({sprite_queue[0][7:0], sprite_queue[1][7:0], sprite_queue[2][7:0],
                          sprite_queue[3][7:0], sprite_queue[4][7:0], sprite_queue[5][7:0]}),
        64'h04_03_01_00_02_05);
`else
    chk("oam_order", 64'({sprite_queue[0][7:0], sprite_queue[1][7:0], sprite_queue[2][7:0],
                         sprite_queue[3][7:0], sprite_queue[4][7:0], sprite_queue[5][7:0]}),
        64'h00_01_02_03_04_05);
`endif

    // Randomized OAM contents and lines.
    for (int t = 0; t < 14; t++) begin
      logic [7:0] ly;
      ly = 8'($urandom_range(0, 143));
      for (int i = 0; i < 40; i++) begin
        int y;
        y = int'(ly) + int'($urandom_range(0, 40));
        if (y > 255) y = 255;
        set_entry(i, 8'(y), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      run_scan(ly, 8'($urandom));
    end

    // Restart 40 cycles into a scan with a different line.
    for (int i = 0; i < 40; i++) set_entry(i, 8'(16 + (i % 20)), 8'(i * 3), 8'(i), 8'(i));
    issue_start(8'd0, 8'h00, k);
    while (cyc < k + 39) @(negedge clk);
    void'(sb.pop_back());
    run_scan(8'd10, 8'h04);
    repeat (200) @(negedge clk);

    // Reset 100 cycles into a scan: outputs drop before the next clock edge.
    issue_start(8'd3, 8'h04, k);
    while (cyc < k + 100) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_oam_a", 64'(oam_a), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_count", 64'(sprite_count), 0);
    chk("arst_queue_or", 64'(|sprite_queue), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 0);

    // Normal operation after reset.
    run_scan(8'd3, 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
